// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scan encoder.
//   state_t       - scan FSM states (SCAN, CONFIRM, HELD)
//   CODE_W        - width of the encoded key (row*4+col)
//   N_LINES       - number of rows and of columns on the keypad
//   *_DEF         - default values of the encoder parameters
//   lowest_row()  - index of the lowest set row bit (row 0 wins)
package keypad_pkg;

   localparam int CODE_W        = 4;
   localparam int N_LINES       = 4;
   localparam int SCAN_HOLD_DEF = 4;
   localparam int DEBOUNCE_DEF  = 3;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_CONFIRM,
      ST_HELD
   } state_t;

   function automatic logic [1:0] lowest_row(input logic [N_LINES-1:0] rows);
      if (rows[0])      return 2'd0;
      else if (rows[1]) return 2'd1;
      else if (rows[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if: keypad-side and key-report signals of the encoder.
//   row_in    - keypad rows (asynchronous), 1 = key closed on driven column
//   col_drv   - one-hot column drive
//   key_code  - last accepted key, row*4+col
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high while the accepted key stays pressed
// master: the encoder; slave: keypad / consumer side.
interface keypad_scan_encoder_if;
   import keypad_pkg::*;

   logic [N_LINES-1:0] row_in;
   logic [N_LINES-1:0] col_drv;
   logic [CODE_W-1:0]  key_code;
   logic               key_valid;
   logic               key_held;

   modport master (
      input  row_in,
      output col_drv,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_drv,
      input  key_code,
      input  key_valid,
      input  key_held
   );

endinterface

// File: rtl/row_sync.sv
// row_sync: 2-flop synchronizer for the asynchronous keypad rows.
//   clk - clock, rst - synchronous active-high reset (clears both flops)
//   d   - asynchronous rows, q - synchronized rows
module row_sync
   import keypad_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LINES-1:0] d,
   output logic [N_LINES-1:0] q
);

   logic [N_LINES-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 keypad column by column, debounces a
// press and its release, and reports one key at a time.
//   clk, rst - clock and synchronous active-high reset
//   kp       - master modport: row_in in; col_drv, key_code, key_valid,
//              key_held out
// Parameters: SCAN_HOLD (cycles per column, 2..255),
//             DEBOUNCE  (matching samples to accept press/release, 1..15)
module keypad_scan_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_HOLD = SCAN_HOLD_DEF,
   parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   keypad_scan_encoder_if.master kp
);

   localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic [N_LINES-1:0] row_s;
   state_t             state, state_nxt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [1:0]         col_idx, col_nxt;
   logic [CODE_W-1:0]  cand, cand_nxt;
   logic [CNT_W-1:0]   match_cnt, match_nxt;
   logic [CNT_W-1:0]   rel_cnt, rel_nxt;
   logic [CODE_W-1:0]  key_code_r, code_nxt;
   logic               key_valid_r, valid_nxt;

   logic               sample;
   logic               any_row;
   logic [1:0]         samp_row;
   logic               key_row_set;

   row_sync u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (kp.row_in),
      .q   (row_s)
   );

   assign sample      = (hold_cnt == HOLD_LAST);
   assign any_row     = |row_s;
   assign samp_row    = lowest_row(row_s);
   assign key_row_set = row_s[key_code_r[3:2]];

   // Hold counter runs continuously; the column only moves on FSM command.
   always_ff @(posedge clk) begin
      if (rst || sample) hold_cnt <= '0;
      else               hold_cnt <= hold_cnt + HOLD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SCAN;
         col_idx     <= 2'd0;
         cand        <= '0;
         match_cnt   <= '0;
         rel_cnt     <= '0;
         key_code_r  <= '0;
         key_valid_r <= 1'b0;
      end else begin
         state       <= state_nxt;
         col_idx     <= col_nxt;
         cand        <= cand_nxt;
         match_cnt   <= match_nxt;
         rel_cnt     <= rel_nxt;
         key_code_r  <= code_nxt;
         key_valid_r <= valid_nxt;
      end
   end

   // Acceptance is decided from the registered count, so the report lands
   // one cycle after the sample that completed the debounce.
   always_comb begin
      state_nxt = state;
      col_nxt   = col_idx;
      cand_nxt  = cand;
      match_nxt = match_cnt;
      rel_nxt   = rel_cnt;
      code_nxt  = key_code_r;
      valid_nxt = 1'b0;
      case (state)
         ST_SCAN: begin
            if (sample) begin
               if (any_row) begin
                  cand_nxt  = {samp_row, col_idx};
                  match_nxt = CNT_W'(1);
                  state_nxt = ST_CONFIRM;
               end else begin
                  col_nxt = col_idx + 2'd1;
               end
            end
         end
         ST_CONFIRM: begin
            if (match_cnt == CNT_MAX) begin
               code_nxt  = cand;
               valid_nxt = 1'b1;
               rel_nxt   = '0;
               match_nxt = '0;
               state_nxt = ST_HELD;
            end else if (sample) begin
               if (any_row && (samp_row == cand[3:2])) begin
                  match_nxt = sat_inc(match_cnt);
               end else begin
                  match_nxt = '0;
                  col_nxt   = col_idx + 2'd1;
                  state_nxt = ST_SCAN;
               end
            end
         end
         ST_HELD: begin
            if (rel_cnt == CNT_MAX) begin
               rel_nxt   = '0;
               col_nxt   = col_idx + 2'd1;
               state_nxt = ST_SCAN;
            end else if (sample) begin
               // Only the reported key's row matters; other rows are ignored.
               if (key_row_set) rel_nxt = '0;
               else             rel_nxt = sat_inc(rel_cnt);
            end
         end
         default: state_nxt = ST_SCAN;
      endcase
   end

   assign kp.col_drv   = 4'b0001 << col_idx;
   assign kp.key_code  = key_code_r;
   assign kp.key_valid = key_valid_r;
   assign kp.key_held  = (state == ST_HELD);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   ecount;
   int   pulses;

   keypad_scan_encoder_if kp_if ();

   keypad_scan_encoder #(
      .SCAN_HOLD (4),
      .DEBOUNCE  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kp_if.key_valid === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, ecount, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ecount++;
   endtask

   task automatic goto(input int n);
      while (ecount < n) tick();
   endtask

   task automatic check_outs(input string tag, input logic [3:0] col, input logic [3:0] code,
                             input logic valid, input logic held);
      check({tag, ".col"},   8'(kp_if.col_drv),   8'(col));
      check({tag, ".code"},  8'(kp_if.key_code),  8'(code));
      check({tag, ".valid"}, 8'(kp_if.key_valid), 8'(valid));
      check({tag, ".held"},  8'(kp_if.key_held),  8'(held));
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      pulses       = 0;
      rst          = 1'b1;
      kp_if.row_in = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      ecount = 0;

      // Idle scanning: each column driven for 4 cycles, wrapping to column 0.
      check_outs("reset", 4'b0001, 4'd0, 1'b0, 1'b0);
      goto(3);  check("idle_e3",  8'(kp_if.col_drv), 8'b0001);
      goto(4);  check("idle_e4",  8'(kp_if.col_drv), 8'b0010);
      goto(8);  check("idle_e8",  8'(kp_if.col_drv), 8'b0100);
      goto(12); check("idle_e12", 8'(kp_if.col_drv), 8'b1000);
      goto(16); check_outs("idle_e16", 4'b0001, 4'd0, 1'b0, 1'b0);
      goto(20); check("idle_e20", 8'(kp_if.col_drv), 8'b0010);

      // Row 2 on column 1: detected at edge 24, accepted at edge 33.
      kp_if.row_in = 4'b0100;
      goto(24); check_outs("r2c1_detect", 4'b0010, 4'd0, 1'b0, 1'b0);
      goto(32); check_outs("r2c1_pre",    4'b0010, 4'd0, 1'b0, 1'b0);
      goto(33); check_outs("r2c1_accept", 4'b0010, 4'd9, 1'b1, 1'b1);
      kp_if.row_in = 4'b0000;
      goto(34); check_outs("r2c1_pulse1", 4'b0010, 4'd9, 1'b0, 1'b1);
      check("pulses_after_key9", 8'(pulses), 8'd1);

      // Release: samples at 36/40/44 see the row clear; key_held drops at 45.
      goto(44); check_outs("rel9_pre",  4'b0010, 4'd9, 1'b0, 1'b1);
      goto(45); check_outs("rel9_done", 4'b0100, 4'd9, 1'b0, 1'b0);

      // Row 0 seen only at the column-2 sample (edge 48): no acceptance.
      kp_if.row_in = 4'b0001;
      goto(48); check("glitch_frozen", 8'(kp_if.col_drv), 8'b0100);
      kp_if.row_in = 4'b0000;
      goto(51); check("glitch_hold", 8'(kp_if.col_drv), 8'b0100);
      goto(52); check_outs("glitch_resume", 4'b1000, 4'd9, 1'b0, 1'b0);
      check("pulses_after_glitch", 8'(pulses), 8'd1);

      // Rows 1 and 3 on column 3: lowest row wins, code 7.
      kp_if.row_in = 4'b1010;
      goto(56); check("r13c3_frozen", 8'(kp_if.col_drv), 8'b1000);
      goto(64); check("r13c3_pre", 8'(kp_if.key_valid), 8'd0);
      goto(65); check_outs("r13c3_accept", 4'b1000, 4'd7, 1'b1, 1'b1);
      // Row 1 released, row 3 still closed: ignored, counts as release.
      kp_if.row_in = 4'b1000;
      goto(66); check("r13c3_pulse1", 8'(kp_if.key_valid), 8'd0);
      goto(76); check("rel7_pre", 8'(kp_if.key_held), 8'd1);
      goto(77); check_outs("rel7_done", 4'b0001, 4'd7, 1'b0, 1'b0);
      kp_if.row_in = 4'b0000;
      check("pulses_after_key7", 8'(pulses), 8'd2);

      // Reset during CONFIRM (detected at column 1, edge 84).
      goto(80);
      kp_if.row_in = 4'b0001;
      goto(84); check("confirm_frozen", 8'(kp_if.col_drv), 8'b0010);
      goto(85);
      rst          = 1'b1;
      kp_if.row_in = 4'b0000;
      goto(86); check_outs("mid_rst", 4'b0001, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      goto(89); check("post_rst_e89", 8'(kp_if.col_drv), 8'b0001);
      goto(90); check("post_rst_e90", 8'(kp_if.col_drv), 8'b0010);
      goto(110);
      check("pulses_final", 8'(pulses), 8'd2);
      check("held_final", 8'(kp_if.key_held), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
